// File: rtl/fb_write_ctrl_pkg.sv
// fb_write_ctrl_pkg: shared widths and FSM encoding for the framebuffer write controller
package fb_write_ctrl_pkg;
  localparam int COLOR_W = 24;
  localparam int COORD_W = 16;
  typedef enum logic [1:0] {IDLE, WRITE, WAIT, CLEAR} state_t;
endpackage

// File: rtl/fb_write_ctrl_pixel_fifo.sv
// fb_write_ctrl_pixel_fifo: synchronous FIFO of precomputed {address, colour} entries with flush
module fb_write_ctrl_pixel_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 43
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  assign dout  = mem_q[rp_q];
  assign count = cnt_q;
  assign full  = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  always_ff @(posedge clk)
    if (push) mem_q[wp_q] <= din;
  // A flush drops everything queued but keeps a same-cycle push as the new head.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_q + AW'(push);
      rp_q  <= flush ? wp_q : rp_q + AW'(pop);
      cnt_q <= flush ? CW'(push) : cnt_q + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/fb_write_ctrl.sv
// fb_write_ctrl: clips and queues pixels, writes them to the framebuffer via req/ack, clears on frame_start
module fb_write_ctrl
  import fb_write_ctrl_pkg::*;
#(
  parameter int                 H_RES    = 640,
  parameter int                 V_RES    = 480,
  parameter int                 ADDR_W   = 19,
  parameter int                 DEPTH    = 8,
  parameter logic [COLOR_W-1:0] BG_COLOR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  input  logic [COLOR_W-1:0] color,
  input  logic               pix_valid,
  output logic               pix_ready,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_data,
  output logic               mem_we,
  input  logic               mem_ack,
  output logic               busy,
  output logic [7:0]         drop_cnt
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = ADDR_W + COLOR_W;
  localparam logic [ADDR_W-1:0]  LAST = ADDR_W'(H_RES * V_RES - 1);
  localparam logic [COORD_W-1:0] HR   = COORD_W'(H_RES);
  localparam logic [COORD_W-1:0] VR   = COORD_W'(V_RES);
  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [COLOR_W-1:0] data_q, data_d;
  logic               we_q, we_d, pend_q, pend_d, ready_q, ready_d, clr;
  logic [7:0]         drop_q, drop_d;
  logic               in_b, acc, push, pop, full, empty;
  logic [CW-1:0]      count, cnt_nx;
  logic [FW-1:0]      din, dout;
  assign in_b   = pixel_x < HR && pixel_y < VR;
  assign acc    = pix_valid && ready_q;
  assign push   = acc && in_b && !full;
  assign pop    = state_q == WRITE && !empty;
  assign din    = {ADDR_W'(pixel_y) * ADDR_W'(H_RES) + ADDR_W'(pixel_x), color};
  assign cnt_nx = frame_start ? CW'(push) : count + CW'(push) - CW'(pop);
  assign ready_d = cnt_nx < CW'(DEPTH);
  assign drop_d  = (acc && !in_b && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  fb_write_ctrl_pixel_fifo #(.DEPTH(DEPTH), .W(FW)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .flush(frame_start),
    .din  (din),
    .dout (dout),
    .full (full),
    .empty(empty),
    .count(count)
  );
  // clr (re)starts the clear at address 0; it overrides whatever the state chose.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = we_q;
    pend_d  = pend_q || frame_start;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        clr     = frame_start;
        state_d = empty ? IDLE : WRITE;
      end
      WRITE: begin
        {addr_d, data_d} = dout;
        we_d    = 1'b1;
        state_d = WAIT;
      end
      WAIT: if (mem_ack) begin
        clr     = pend_d;
        we_d    = 1'b0;
        state_d = empty ? IDLE : WRITE;
      end
      CLEAR: if (mem_ack) begin
        clr     = pend_d;
        addr_d  = addr_q == LAST ? addr_q : addr_q + 1'b1;
        we_d    = addr_q != LAST;
        state_d = addr_q != LAST ? CLEAR : empty ? IDLE : WRITE;
      end
      default: state_d = IDLE;
    endcase
    if (clr) begin
      state_d = CLEAR;
      addr_d  = '0;
      data_d  = BG_COLOR;
      we_d    = 1'b1;
      pend_d  = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      pend_q  <= 1'b0;
      ready_q <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      pend_q  <= pend_d;
      ready_q <= ready_d;
      drop_q  <= drop_d;
    end
  assign pix_ready = ready_q;
  assign mem_addr  = addr_q;
  assign mem_data  = data_q;
  assign mem_we    = we_q;
  assign busy      = state_q == CLEAR;
  assign drop_cnt  = drop_q;
endmodule

// File: tb/tb_fb_write_ctrl.sv
// tb_fb_write_ctrl: directed checks of fb_write_ctrl on a 4x3 screen with a 4-entry FIFO
module tb_fb_write_ctrl;
  localparam logic [23:0] BG = 24'h5A5A5A;
  logic        clk = 1'b0;
  logic        rst, frame_start, pix_valid, pix_ready, mem_we, mem_ack, busy;
  logic [15:0] pixel_x, pixel_y;
  logic [23:0] color, mem_data;
  logic [18:0] mem_addr;
  logic [7:0]  drop_cnt;
  int chk = 0;
  int err = 0;
  fb_write_ctrl #(.H_RES(4), .V_RES(3), .ADDR_W(19), .DEPTH(4), .BG_COLOR(BG)) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .color      (color),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_we     (mem_we),
    .mem_ack    (mem_ack),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic px(input logic [15:0] x, input logic [15:0] y, input logic [23:0] c);
    pix_valid = 1'b1;
    pixel_x   = x;
    pixel_y   = y;
    color     = c;
  endtask
  // With mem_ack high, every sampled cycle showing mem_we=1 is one completed write.
  task automatic wait_write(input logic [18:0] a, input logic [23:0] d);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (mem_we) begin
        found = 1'b1;
        check("write_addr", 64'(mem_addr), 64'(a));
        check("write_data", 64'(mem_data), 64'(d));
      end
      step();
    end
    check("write_timeout", 64'(found), 64'd1);
  endtask
  initial begin
    rst = 1'b0; frame_start = 1'b0; pix_valid = 1'b0; mem_ack = 1'b1;
    pixel_x = '0; pixel_y = '0; color = '0;
    #12;
    check("rst_ready", 64'(pix_ready), 64'd0);
    check("rst_we", 64'(mem_we), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_data", 64'(mem_data), 64'd0);
    rst = 1'b1;
    step();
    check("t1_ready", 64'(pix_ready), 64'd1);
    px(1, 2, 24'hABCDEF);
    step();
    pix_valid = 1'b0;
    check("t1_we_n", 64'(mem_we), 64'd0);
    step();
    check("t1_we_n1", 64'(mem_we), 64'd0);
    step();
    check("t1_we_n2", 64'(mem_we), 64'd1);
    check("t1_addr", 64'(mem_addr), 64'd9);
    check("t1_data", 64'(mem_data), 64'hABCDEF);
    step();
    check("t1_done", 64'(mem_we), 64'd0);
    mem_ack = 1'b0;
    px(0, 0, 24'h111111); step();
    px(1, 0, 24'h222222); step();
    px(2, 0, 24'h333333); step();
    px(3, 0, 24'h444444); step();
    px(0, 1, 24'h555555); step();
    px(3, 2, 24'h999999);
    check("t2_ready", 64'(pix_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      check("t2_hold_we", 64'(mem_we), 64'd1);
      check("t2_hold_addr", 64'(mem_addr), 64'd0);
      check("t2_hold_data", 64'(mem_data), 64'h111111);
      step();
    end
    pix_valid = 1'b0;
    mem_ack = 1'b1;
    wait_write(0, 24'h111111);
    wait_write(1, 24'h222222);
    wait_write(2, 24'h333333);
    wait_write(3, 24'h444444);
    wait_write(4, 24'h555555);
    for (int i = 0; i < 6; i++) begin
      check("t2_idle_we", 64'(mem_we), 64'd0);
      step();
    end
    px(4, 0, 24'h010101); step();
    px(0, 3, 24'h020202); step();
    pix_valid = 1'b0;
    check("t3_drop2", 64'(drop_cnt), 64'd2);
    for (int i = 0; i < 4; i++) begin
      check("t3_no_we", 64'(mem_we), 64'd0);
      step();
    end
    px(100, 100, 24'h030303);
    for (int i = 0; i < 252; i++) step();
    check("t3_drop254", 64'(drop_cnt), 64'd254);
    step();
    check("t3_drop255", 64'(drop_cnt), 64'd255);
    for (int i = 0; i < 47; i++) step();
    check("t3_sat", 64'(drop_cnt), 64'd255);
    pix_valid = 1'b0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      check("t4_busy", 64'(busy), 64'd1);
      if (k == 5) px(3, 2, 24'hC0FFEE);
      wait_write(19'(k), BG);
      pix_valid = 1'b0;
    end
    check("t4_busy_end", 64'(busy), 64'd0);
    wait_write(11, 24'hC0FFEE);
    check("t4_after", 64'(mem_we), 64'd0);
    mem_ack = 1'b0;
    px(0, 0, 24'hA1A1A1); step();
    px(1, 0, 24'hA2A2A2); step();
    px(2, 0, 24'hA3A3A3); step();
    px(3, 0, 24'hA4A4A4); step();
    check("t5_ready", 64'(pix_ready), 64'd1);
    px(1, 1, 24'hBEEF01);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    pix_valid = 1'b0;
    check("t5_busy_wait", 64'(busy), 64'd0);
    check("t5_inflight_addr", 64'(mem_addr), 64'd0);
    check("t5_inflight_data", 64'(mem_data), 64'hA1A1A1);
    mem_ack = 1'b1;
    wait_write(0, 24'hA1A1A1);
    for (int k = 0; k < 12; k++) begin
      check("t5_busy", 64'(busy), 64'd1);
      wait_write(19'(k), BG);
    end
    check("t5_busy_end", 64'(busy), 64'd0);
    wait_write(5, 24'hBEEF01);
    for (int i = 0; i < 8; i++) begin
      check("t5_no_more", 64'(mem_we), 64'd0);
      step();
    end
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
    step();
    check("t6_pre_we", 64'(mem_we), 64'd1);
    check("t6_pre_busy", 64'(busy), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("t6_we", 64'(mem_we), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_drop", 64'(drop_cnt), 64'd0);
    check("t6_ready", 64'(pix_ready), 64'd0);
    check("t6_addr", 64'(mem_addr), 64'd0);
    #2;
    rst = 1'b1;
    step();
    check("t6_ready_rel", 64'(pix_ready), 64'd1);
    for (int i = 0; i < 10; i++) begin
      check("t6_quiet", 64'(mem_we), 64'd0);
      step();
    end
    px(2, 1, 24'h777777);
    step();
    pix_valid = 1'b0;
    wait_write(6, 24'h777777);
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule
